// File: rtl/fpu_core_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// fpu_core_arbiter: round-robin NB_CORES:1 arbiter onto a shared FPU port,
// with in-order response routing via an issuing-core ID FIFO.   Rev 1.0
// ----------------------------------------------------------------------------
module fpu_core_arbiter #(
  parameter int NB_CORES      = 4,
  parameter int DATA_WIDTH    = 32,
  parameter int NB_ARGS       = 3,
  parameter int OPCODE_WIDTH  = 6,
  parameter int DSFLAGS_CPU   = 15,
  parameter int USFLAGS_CPU   = 5,
  parameter int ID_FIFO_DEPTH = 4
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic [NB_CORES-1:0]                      core_req_i,
  output logic [NB_CORES-1:0]                      core_gnt_o,
  input  logic [NB_CORES*NB_ARGS*DATA_WIDTH-1:0]   core_operands_i,
  input  logic [NB_CORES*OPCODE_WIDTH-1:0]         core_op_i,
  input  logic [NB_CORES*DSFLAGS_CPU-1:0]          core_flags_i,
  input  logic [NB_CORES-1:0]                      core_rready_i,
  output logic [NB_CORES-1:0]                      core_rvalid_o,
  output logic [DATA_WIDTH-1:0]                    core_rdata_o,
  output logic [USFLAGS_CPU-1:0]                   core_rflags_o,
  output logic                                     fpu_req_o,
  input  logic                                     fpu_gnt_i,
  output logic [NB_ARGS*DATA_WIDTH-1:0]            fpu_operands_o,
  output logic [OPCODE_WIDTH-1:0]                  fpu_op_o,
  output logic [DSFLAGS_CPU-1:0]                   fpu_flags_o,
  output logic                                     fpu_rready_o,
  input  logic                                     fpu_rvalid_i,
  input  logic [DATA_WIDTH-1:0]                    fpu_rdata_i,
  input  logic [USFLAGS_CPU-1:0]                   fpu_rflags_i,
  output logic [$clog2(ID_FIFO_DEPTH):0]           outstanding_o,
  output logic                                     err_o
);

  localparam int IDX_W = $clog2(NB_CORES);
  localparam int PTR_W = $clog2(ID_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OPS_W = NB_ARGS * DATA_WIDTH;

  logic [IDX_W-1:0] rr_ptr, lock_idx, search_idx, winner, head;
  logic             lock_active, any_req, full, empty, push, pop, found;
  logic [IDX_W:0]   cand;
  logic [IDX_W-1:0] id_mem [ID_FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;

  // First requester at or after the RR pointer, wrapping modulo NB_CORES.
  always_comb begin
    search_idx = '0;
    found      = 1'b0;
    cand       = '0;
    for (int i = 0; i < NB_CORES; i++) begin
      cand = {1'b0, rr_ptr} + (IDX_W+1)'(i);
      if (cand >= (IDX_W+1)'(NB_CORES)) cand = cand - (IDX_W+1)'(NB_CORES);
      if (!found && core_req_i[cand[IDX_W-1:0]]) begin
        found      = 1'b1;
        search_idx = cand[IDX_W-1:0];
      end
    end
  end

  assign winner    = lock_active ? lock_idx : search_idx;
  assign any_req   = |core_req_i;
  assign full      = (count == CNT_W'(ID_FIFO_DEPTH));
  assign empty     = (count == '0);
  assign fpu_req_o = any_req & ~full;
  assign push      = fpu_req_o & fpu_gnt_i;
  assign core_gnt_o = push ? (NB_CORES'(1) << winner) : '0;

  always_comb begin
    fpu_operands_o = core_operands_i[OPS_W-1:0];
    fpu_op_o       = core_op_i[OPCODE_WIDTH-1:0];
    fpu_flags_o    = core_flags_i[DSFLAGS_CPU-1:0];
    for (int k = 1; k < NB_CORES; k++) begin
      if (winner == IDX_W'(k)) begin
        fpu_operands_o = core_operands_i[k*OPS_W +: OPS_W];
        fpu_op_o       = core_op_i[k*OPCODE_WIDTH +: OPCODE_WIDTH];
        fpu_flags_o    = core_flags_i[k*DSFLAGS_CPU +: DSFLAGS_CPU];
      end
    end
  end

  // An empty FIFO still accepts rvalid so stray responses are drained.
  assign head          = id_mem[rd_ptr];
  assign fpu_rready_o  = empty ? fpu_rvalid_i : core_rready_i[head];
  assign core_rvalid_o = (!empty && fpu_rvalid_i) ? (NB_CORES'(1) << head) : '0;
  assign pop           = fpu_rvalid_i & fpu_rready_o & ~empty;
  assign core_rdata_o  = fpu_rdata_i;
  assign core_rflags_o = fpu_rflags_i;
  assign outstanding_o = count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      lock_active <= 1'b0;
      lock_idx    <= '0;
    end else if (push) begin
      rr_ptr      <= (winner == IDX_W'(NB_CORES-1)) ? '0 : winner + IDX_W'(1);
      lock_active <= 1'b0;
    end else if (fpu_req_o) begin
      lock_active <= 1'b1;
      lock_idx    <= winner;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err_o  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (fpu_rvalid_i && empty) err_o <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) id_mem[wr_ptr] <= winner;
  end

endmodule
`default_nettype wire

// File: tb/tb_fpu_core_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_fpu_core_arbiter: directed self-checking bench for fpu_core_arbiter.
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_fpu_core_arbiter;
  localparam int NC = 4, DW = 32, NA = 3, OW = 6, DF = 15, UF = 5, FD = 4;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     core_req_i, core_gnt_o, core_rready_i, core_rvalid_o;
  logic [NC*NA*DW-1:0] core_operands_i;
  logic [NC*OW-1:0]  core_op_i;
  logic [NC*DF-1:0]  core_flags_i;
  logic [DW-1:0]     core_rdata_o, fpu_rdata_i;
  logic [UF-1:0]     core_rflags_o, fpu_rflags_i;
  logic              fpu_req_o, fpu_gnt_i, fpu_rready_o, fpu_rvalid_i, err_o;
  logic [NA*DW-1:0]  fpu_operands_o;
  logic [OW-1:0]     fpu_op_o;
  logic [DF-1:0]     fpu_flags_o;
  logic [2:0]        outstanding_o;
  int checks = 0;
  int failures = 0;

  fpu_core_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .core_req_i(core_req_i), .core_gnt_o(core_gnt_o),
    .core_operands_i(core_operands_i), .core_op_i(core_op_i), .core_flags_i(core_flags_i),
    .core_rready_i(core_rready_i), .core_rvalid_o(core_rvalid_o),
    .core_rdata_o(core_rdata_o), .core_rflags_o(core_rflags_o),
    .fpu_req_o(fpu_req_o), .fpu_gnt_i(fpu_gnt_i),
    .fpu_operands_o(fpu_operands_o), .fpu_op_o(fpu_op_o), .fpu_flags_o(fpu_flags_o),
    .fpu_rready_o(fpu_rready_o), .fpu_rvalid_i(fpu_rvalid_i),
    .fpu_rdata_i(fpu_rdata_i), .fpu_rflags_i(fpu_rflags_i),
    .outstanding_o(outstanding_o), .err_o(err_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; core_req_i = '0; core_rready_i = '0; fpu_gnt_i = 1'b0;
    fpu_rvalid_i = 1'b0; fpu_rdata_i = '0; fpu_rflags_i = '0;
    for (int k = 0; k < NC; k++) begin
      core_op_i[k*OW +: OW]           = OW'(16 + k);
      core_flags_i[k*DF +: DF]        = DF'(256 + k);
      core_operands_i[k*NA*DW +: NA*DW] = {3{32'hC0DE0000 + 32'(k)}};
    end
    repeat (3) @(posedge clk);
    #2;
    checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL reset_outstanding got=%0d exp=0", outstanding_o); end
    checks++; if (err_o !== 1'b0) begin failures++; $display("FAIL reset_err got=%b exp=0", err_o); end
    checks++; if ({fpu_req_o, fpu_rready_o, core_gnt_o, core_rvalid_o} !== 10'd0) begin
      failures++; $display("FAIL reset_outputs got=%b%b%b%b exp=0", fpu_req_o, fpu_rready_o, core_gnt_o, core_rvalid_o); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NC-1:0] exp_v;
    core_req_i = 4'b1111; fpu_gnt_i = 1'b1; core_rready_i = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_v = 4'b0001 << i;
      checks++; if (core_gnt_o !== exp_v) begin failures++; $display("FAIL rr_gnt%0d got=%b exp=%b", i, core_gnt_o, exp_v); end
      checks++; if (fpu_op_o !== OW'(16 + i)) begin failures++; $display("FAIL rr_op%0d got=%h exp=%h", i, fpu_op_o, 16 + i); end
      checks++; if (fpu_operands_o !== {3{32'hC0DE0000 + 32'(i)}}) begin failures++; $display("FAIL rr_operands%0d got=%h", i, fpu_operands_o); end
      checks++; if (outstanding_o !== 3'(i)) begin failures++; $display("FAIL rr_count%0d got=%0d exp=%0d", i, outstanding_o, i); end
      tick();
    end
    #1;
    checks++; if (outstanding_o !== 3'd4) begin failures++; $display("FAIL rr_full_count got=%0d exp=4", outstanding_o); end
    checks++; if (fpu_req_o !== 1'b0 || core_gnt_o !== 4'b0) begin failures++; $display("FAIL rr_full_req got=%b/%b exp=0/0000", fpu_req_o, core_gnt_o); end
    // full with a simultaneous pop: request must stay blocked
    fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'h1234_5678; fpu_rflags_i = 5'h11;
    #1;
    checks++; if (fpu_req_o !== 1'b0 || core_gnt_o !== 4'b0) begin failures++; $display("FAIL full_no_bypass got=%b/%b exp=0/0000", fpu_req_o, core_gnt_o); end
    checks++; if (core_rvalid_o !== 4'b0001) begin failures++; $display("FAIL full_pop_rvalid got=%b exp=0001", core_rvalid_o); end
    checks++; if (core_rdata_o !== 32'h1234_5678 || core_rflags_o !== 5'h11) begin failures++; $display("FAIL rdata_pass got=%h/%h exp=12345678/11", core_rdata_o, core_rflags_o); end
    tick();
    #1;
    checks++; if (core_gnt_o !== 4'b0001) begin failures++; $display("FAIL rr_wrap_gnt got=%b exp=0001", core_gnt_o); end
    checks++; if (core_rvalid_o !== 4'b0010) begin failures++; $display("FAIL rr_pop1 got=%b exp=0010", core_rvalid_o); end
    checks++; if (outstanding_o !== 3'd3) begin failures++; $display("FAIL rr_count_after_pop got=%0d exp=3", outstanding_o); end
    tick();
    core_req_i = '0;
    for (int h = 2; h < 5; h++) begin
      #1;
      exp_v = 4'b0001 << (h % 4);
      checks++; if (core_rvalid_o !== exp_v) begin failures++; $display("FAIL rr_drain%0d got=%b exp=%b", h, core_rvalid_o, exp_v); end
      tick();
    end
    fpu_rvalid_i = 1'b0;
    #1;
    checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL rr_empty got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_lock();
    core_req_i = 4'b0100; fpu_gnt_i = 1'b0;
    #1;
    checks++; if (fpu_req_o !== 1'b1 || fpu_op_o !== 6'h12) begin failures++; $display("FAIL lock_first got=%b/%h exp=1/12", fpu_req_o, fpu_op_o); end
    tick();
    core_req_i = 4'b0110;
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++; if (fpu_op_o !== 6'h12 || fpu_flags_o !== 15'h102 || core_gnt_o !== 4'b0) begin
        failures++; $display("FAIL lock_hold%0d got=%h/%h/%b exp=12/102/0000", c, fpu_op_o, fpu_flags_o, core_gnt_o); end
      if (c < 2) tick();
    end
    fpu_gnt_i = 1'b1;
    #1;
    checks++; if (core_gnt_o !== 4'b0100) begin failures++; $display("FAIL lock_grant got=%b exp=0100", core_gnt_o); end
    tick();
    core_req_i = 4'b0010;
    #1;
    checks++; if (core_gnt_o !== 4'b0010) begin failures++; $display("FAIL lock_next got=%b exp=0010", core_gnt_o); end
    tick();
    core_req_i = '0; fpu_gnt_i = 1'b0; fpu_rvalid_i = 1'b1;
    #1;
    checks++; if (core_rvalid_o !== 4'b0100) begin failures++; $display("FAIL lock_resp0 got=%b exp=0100", core_rvalid_o); end
    tick();
    #1;
    checks++; if (core_rvalid_o !== 4'b0010) begin failures++; $display("FAIL lock_resp1 got=%b exp=0010", core_rvalid_o); end
    tick();
    fpu_rvalid_i = 1'b0;
  endtask

  task automatic test_order();
    logic [NC-1:0] cores [3];
    logic [DW-1:0] data [3];
    cores = '{4'b0010, 4'b1000, 4'b0010};
    data  = '{32'hA, 32'hB, 32'hC};
    fpu_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      core_req_i = cores[i];
      #1;
      checks++; if (core_gnt_o !== cores[i]) begin failures++; $display("FAIL order_gnt%0d got=%b exp=%b", i, core_gnt_o, cores[i]); end
      tick();
    end
    core_req_i = '0; fpu_gnt_i = 1'b0;
    #1;
    checks++; if (outstanding_o !== 3'd3) begin failures++; $display("FAIL order_count got=%0d exp=3", outstanding_o); end
    for (int i = 0; i < 3; i++) begin
      fpu_rvalid_i = 1'b1; fpu_rdata_i = data[i]; fpu_rflags_i = UF'(i + 1);
      #1;
      checks++; if (core_rvalid_o !== cores[i] || core_rdata_o !== data[i] || core_rflags_o !== UF'(i + 1)) begin
        failures++; $display("FAIL order_resp%0d got=%b/%h/%h exp=%b/%h/%h", i, core_rvalid_o, core_rdata_o, core_rflags_o, cores[i], data[i], i + 1); end
      tick();
    end
    fpu_rvalid_i = 1'b0;
    #1;
    checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL order_empty got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_stall();
    core_req_i = 4'b1000; fpu_gnt_i = 1'b1;
    tick();
    core_req_i = 4'b0001; fpu_rvalid_i = 1'b1; fpu_rdata_i = 32'hDEAD_BEEF; core_rready_i = 4'b0111;
    for (int s = 0; s < 4; s++) begin
      #1;
      checks++; if (fpu_rready_o !== 1'b0 || core_rvalid_o !== 4'b1000) begin
        failures++; $display("FAIL stall%0d got=%b/%b exp=0/1000", s, fpu_rready_o, core_rvalid_o); end
      if (s == 0) begin
        checks++; if (core_gnt_o !== 4'b0001) begin failures++; $display("FAIL stall_req_side got=%b exp=0001", core_gnt_o); end
      end
      tick();
      core_req_i = '0;
    end
    #1;
    checks++; if (outstanding_o !== 3'd2) begin failures++; $display("FAIL stall_count got=%0d exp=2", outstanding_o); end
    core_rready_i = 4'b1111;
    #1;
    checks++; if (fpu_rready_o !== 1'b1 || core_rvalid_o !== 4'b1000 || core_rdata_o !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL stall_release got=%b/%b/%h exp=1/1000/deadbeef", fpu_rready_o, core_rvalid_o, core_rdata_o); end
    tick();
    #1;
    checks++; if (outstanding_o !== 3'd1 || core_rvalid_o !== 4'b0001) begin
      failures++; $display("FAIL stall_single_pop got=%0d/%b exp=1/0001", outstanding_o, core_rvalid_o); end
    tick();
    fpu_rvalid_i = 1'b0;
    #1;
    checks++; if (outstanding_o !== 3'd0) begin failures++; $display("FAIL stall_empty got=%0d exp=0", outstanding_o); end
  endtask

  task automatic test_back_to_back();
    logic [NC-1:0] exp_v;
    fpu_gnt_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      core_req_i = 4'b0001 << i;
      tick();
    end
    core_req_i = '0;
    #1;
    checks++; if (outstanding_o !== 3'd3) begin failures++; $display("FAIL b2b_fill got=%0d exp=3", outstanding_o); end
    core_req_i = 4'b1000; fpu_rvalid_i = 1'b1;
    #1;
    checks++; if (core_gnt_o !== 4'b1000 || core_rvalid_o !== 4'b0001) begin
      failures++; $display("FAIL b2b_same_cycle got=%b/%b exp=1000/0001", core_gnt_o, core_rvalid_o); end
    tick();
    core_req_i = '0;
    #1;
    checks++; if (outstanding_o !== 3'd3) begin failures++; $display("FAIL b2b_count got=%0d exp=3", outstanding_o); end
    for (int h = 1; h < 4; h++) begin
      #1;
      exp_v = 4'b0001 << h;
      checks++; if (core_rvalid_o !== exp_v) begin failures++; $display("FAIL b2b_order%0d got=%b exp=%b", h, core_rvalid_o, exp_v); end
      tick();
    end
    fpu_rvalid_i = 1'b0; fpu_gnt_i = 1'b0;
  endtask

  task automatic test_err();
    core_rready_i = '0; fpu_rvalid_i = 1'b1;
    #1;
    checks++; if (fpu_rready_o !== 1'b1 || core_rvalid_o !== 4'b0 || err_o !== 1'b0) begin
      failures++; $display("FAIL err_drain got=%b/%b/%b exp=1/0000/0", fpu_rready_o, core_rvalid_o, err_o); end
    tick();
    fpu_rvalid_i = 1'b0;
    #1;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_set got=%b exp=1", err_o); end
    tick();
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_sticky got=%b exp=1", err_o); end
    core_req_i = 4'b0001; fpu_gnt_i = 1'b1;
    tick();
    core_req_i = '0; fpu_gnt_i = 1'b0;
    #1;
    checks++; if (outstanding_o !== 3'd1) begin failures++; $display("FAIL err_push got=%0d exp=1", outstanding_o); end
    rst_n = 1'b0;
    #1;
    checks++; if (err_o !== 1'b0 || outstanding_o !== 3'd0) begin
      failures++; $display("FAIL async_reset got=%b/%0d exp=0/0", err_o, outstanding_o); end
    @(negedge clk);
    rst_n = 1'b1;
    fpu_rvalid_i = 1'b1; core_rready_i = 4'b1111;
    #1;
    checks++; if (core_rvalid_o !== 4'b0 || fpu_rready_o !== 1'b1) begin
      failures++; $display("FAIL inflight_after_reset got=%b/%b exp=0000/1", core_rvalid_o, fpu_rready_o); end
    tick();
    fpu_rvalid_i = 1'b0;
    checks++; if (err_o !== 1'b1) begin failures++; $display("FAIL err_after_reset got=%b exp=1", err_o); end
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_lock();
    test_order();
    test_stall();
    test_back_to_back();
    test_err();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
